// File: rtl/instr_fetch_axi.sv
// instr_fetch_axi
//   AXI4-Lite read master that turns instruction-fetch requests from the core
//   into single-beat AXI reads and returns the selected 32-bit instruction.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   instr_rd_en_i, pc_i        fetch request and its address
//   flush_i                    taken jump: drop the result of any fetch in flight
//   instr_o, addr_instr_o      registered instruction and its address
//   instr_valid_o              one-cycle pulse when instr_o/addr_instr_o update
//   fetch_err_o                misaligned PC or AXI error, valid with instr_valid_o
//   stall_if_o                 fetch in progress, core holds PC
//   axi_idle_o                 no AXI transaction outstanding
//   ar_valid_o/ar_ready_i/ar_addr_o/ar_prot_o   AXI read address channel
//   r_valid_i/r_ready_o/r_data_i/r_resp_i       AXI read data channel
module instr_fetch_axi #(
  parameter int unsigned        ADDR_W    = 64,
  parameter int unsigned        DATA_W    = 64,
  parameter int unsigned        INSTR_W   = 32,
  parameter logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_rd_en_i,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              flush_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [ADDR_W-1:0] addr_instr_o,
  output logic              instr_valid_o,
  output logic              fetch_err_o,
  output logic              stall_if_o,
  output logic              axi_idle_o,
  output logic              ar_valid_o,
  input  logic              ar_ready_i,
  output logic [ADDR_W-1:0] ar_addr_o,
  output logic [2:0]        ar_prot_o,
  input  logic              r_valid_i,
  output logic              r_ready_o,
  input  logic [DATA_W-1:0] r_data_i,
  input  logic [1:0]        r_resp_i
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t             state;
  state_t             state_next;
  logic [ADDR_W-1:0]  pc_q;
  logic               discard;
  logic               aligned;
  logic               unused_resp;

  // Only the SLVERR/DECERR bit matters; OKAY vs EXOKAY is irrelevant here.
  assign unused_resp = r_resp_i[0];
  assign aligned     = (pc_i[1:0] == 2'b00);

  // Pick the 32-bit half of the 64-bit beat addressed by bit 2 of the PC.
  function automatic logic [INSTR_W-1:0] select_word(input logic upper,
                                                     input logic [DATA_W-1:0] data);
    return upper ? data[63:32] : data[31:0];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (instr_rd_en_i && aligned) state_next = ADDR;
      ADDR: if (ar_ready_i)               state_next = DATA;
      DATA: if (r_valid_i)                state_next = IDLE;
      default:                            state_next = IDLE;
    endcase
  end

  assign ar_valid_o = (state == ADDR);
  assign r_ready_o  = (state == DATA);
  assign stall_if_o = (state != IDLE);
  assign axi_idle_o = (state == IDLE);
  assign ar_addr_o  = {pc_q[ADDR_W-1:3], 3'b000};
  assign ar_prot_o  = 3'b100;

  // Result register: updated on a misaligned request or an undiscarded R beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_o       <= NOP_INSTR;
      addr_instr_o  <= '0;
      instr_valid_o <= 1'b0;
      fetch_err_o   <= 1'b0;
      pc_q          <= '0;
      discard       <= 1'b0;
    end else begin
      instr_valid_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (instr_rd_en_i) begin
            if (aligned) begin
              pc_q    <= pc_i;
              discard <= 1'b0;
            end else begin
              instr_valid_o <= 1'b1;
              fetch_err_o   <= 1'b1;
              instr_o       <= NOP_INSTR;
              addr_instr_o  <= pc_i;
            end
          end
        end
        ADDR: begin
          if (flush_i) discard <= 1'b1;
        end
        DATA: begin
          if (r_valid_i) begin
            discard <= 1'b0;
            // A flush in the handshake cycle itself must also drop the beat.
            if (!(discard || flush_i)) begin
              instr_valid_o <= 1'b1;
              addr_instr_o  <= pc_q;
              fetch_err_o   <= r_resp_i[1];
              instr_o       <= r_resp_i[1] ? NOP_INSTR : select_word(pc_q[2], r_data_i);
            end
          end else if (flush_i) begin
            discard <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
